// File: rtl/mem_byte_sequencer_pkg.sv
// Shared definitions for the byte-serial load/store sequencer: opcodes,
// access-size encoding, FSM states and opcode classification helpers.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    // Encoded as (bytes - 1) so the value doubles as the last byte index.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RDLAST,
        ST_DONE
    } state_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_unsigned(input logic [5:0] op);
        return (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic size_e op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer_ld_extend.sv
// Sign/zero extension of an assembled big-endian load value. The bytes of
// the access sit right-justified in 'assembled'.
module ld_extend
    import mips_mem_pkg::*;
(
    input  size_e       size,
    input  logic        is_uns,
    input  logic [31:0] assembled,
    output logic [31:0] result
);

    // Extend from bit 7 or 15 depending on access size; words pass through.
    always_comb begin
        result = assembled;
        case (size)
            SZ_B: result = is_uns ? {24'd0, assembled[7:0]}
                                  : {{24{assembled[7]}}, assembled[7:0]};
            SZ_H: result = is_uns ? {16'd0, assembled[15:0]}
                                  : {{16{assembled[15]}}, assembled[15:0]};
            default: result = assembled;
        endcase
    end

endmodule

// File: rtl/mem_byte_sequencer.sv
// Load/store sequencer in front of a byte-wide data memory. Accepts one
// MEM-stage request, performs alignment/range checks, then issues one byte
// access per cycle, most significant byte at the lowest address.
module mem_byte_sequencer
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        opcode,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       load_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_e              state;
    state_e              next_state;
    logic [5:0]          op_q;
    logic [ADDR_W-1:0]   base_q;
    logic [31:0]         wdata_q;
    logic [1:0]          idx_q;
    logic                fault_q;
    logic [23:0]         shift_q;

    logic                accept;
    logic                bad_access;
    size_e               req_size;
    size_e               size_q;
    logic                load_q;
    logic [1:0]          byte_sel;
    logic [31:0]         assembled;
    logic [31:0]         extended;

    assign req_size   = op_size(opcode);
    assign accept     = (state == ST_IDLE) && req_valid && is_legal(opcode);
    assign bad_access = ((req_size == SZ_H) && addr[0]) ||
                        ((req_size == SZ_W) && (addr[1:0] != 2'b00)) ||
                        (addr[31:ADDR_W] != '0);

    assign size_q   = op_size(op_q);
    assign load_q   = is_load(op_q);
    // Stores go out MSB first: byte i comes from position (N-1-i) of wdata.
    assign byte_sel = size_q - idx_q;
    // The final byte is still on mem_rdata when the load result is formed.
    assign assembled = {shift_q, mem_rdata};

    ld_extend u_ld_extend (
        .size      (size_q),
        .is_uns    (is_unsigned(op_q)),
        .assembled (assembled),
        .result    (extended)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Control state: byte index, fault flag and the visible load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= 2'd0;
            fault_q   <= 1'b0;
            load_data <= 32'd0;
        end else begin
            if (accept) begin
                idx_q   <= 2'd0;
                fault_q <= bad_access;
            end else if (state == ST_ACCESS) begin
                idx_q <= idx_q + 2'd1;
            end
            if (state == ST_RDLAST) begin
                load_data <= extended;
            end
        end
    end

    // Request latches and load byte shift register; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= opcode;
            base_q  <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
        end
        if (load_q && (((state == ST_ACCESS) && (idx_q != 2'd0)) ||
                       (state == ST_RDLAST))) begin
            shift_q <= {shift_q[15:0], mem_rdata};
        end
    end

    // Next-state selection and Moore outputs.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        fault      = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'd0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    next_state = bad_access ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_addr = base_q + ADDR_W'(idx_q);
                if (load_q) begin
                    mem_re = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q[{byte_sel, 3'b000} +: 8];
                end
                if (idx_q == size_q) begin
                    next_state = load_q ? ST_RDLAST : ST_DONE;
                end
            end
            ST_RDLAST: begin
                next_state = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                fault      = fault_q;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer: byte memory, transaction-level reference
// model, per-cycle output compare and directed plus random requests.
module tb_mem_byte_sequencer;

    localparam int ADDR_W = 8;
    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] OPS [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        req_ready, busy, done, fault, mem_we, mem_re;
    logic [31:0] load_data;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  tb_mem  [256];
    logic [7:0]  ref_mem [256];
    int          ntotal = 0;
    int          npass = 0;
    int          strobe_cnt = 0;

    // One entry per expected non-idle cycle of the DUT.
    typedef struct {
        logic       done, fault, we, re, ld_upd;
        logic [7:0] a, d;
        logic [31:0] ld;
    } ent_t;
    ent_t        exp_q[$];
    logic [31:0] model_ld = 32'd0;

    mem_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .opcode    (opcode),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .load_data (load_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte memory: synchronous write, read data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= tb_mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    function automatic bit legal(input logic [5:0] op);
        for (int i = 0; i < 8; i++) if (OPS[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_ld(input logic [5:0] op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic int op_bytes(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic bit is_bad(input logic [5:0] op, input logic [31:0] a);
        int n;
        n = op_bytes(op);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00) || (a >= (32'd1 << ADDR_W));
    endfunction

    // Expand one accepted request into its expected cycle sequence.
    task automatic model_accept(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
        ent_t e;
        int n;
        logic [31:0] v;
        n = op_bytes(op);
        e = '{default: '0};
        if (is_bad(op, a)) begin
            e.done = 1'b1;
            e.fault = 1'b1;
            exp_q.push_back(e);
            return;
        end
        for (int i = 0; i < n; i++) begin
            e = '{default: '0};
            e.a = 8'(a + 32'(i));
            if (is_ld(op)) e.re = 1'b1;
            else begin
                e.we = 1'b1;
                e.d  = 8'(wd >> (8 * (n - 1 - i)));
            end
            exp_q.push_back(e);
        end
        e = '{default: '0};
        if (is_ld(op)) begin
            exp_q.push_back(e);
            v = 32'd0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[8'(a + 32'(i))]);
            if (op == LB && v[7])  v = v | 32'hFFFF_FF00;
            if (op == LH && v[15]) v = v | 32'hFFFF_0000;
            e.ld_upd = 1'b1;
            e.ld = v;
        end
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        ent_t e;
        bit idle;
        e = '{default: '0};
        idle = 1'b1;
        if (!rst_n) begin
            exp_q.delete();
            model_ld = 32'd0;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            idle = 1'b0;
        end
        if (e.we) ref_mem[e.a] = e.d;
        if (e.ld_upd) model_ld = e.ld;
        if (mem_we || mem_re) strobe_cnt++;
        chk("ctrl{ready,busy,done,fault,we,re}",
            {26'd0, req_ready, busy, done, fault, mem_we, mem_re},
            {26'd0, idle, !idle, e.done, e.fault, e.we, e.re});
        if (e.we || e.re) chk("mem_addr", 32'(mem_addr), 32'(e.a));
        if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.d));
        chk("load_data", load_data, model_ld);
        if (rst_n && idle && req_valid && legal(opcode)) model_accept(opcode, addr, wdata);
    end

    // Issue one request from IDLE and wait (bounded) for done.
    task automatic run_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic flt, output logic [31:0] ld);
        req_valid = 1'b1;
        opcode = op;
        addr = a;
        wdata = wd;
        @(posedge clk); #2;
        req_valid = 1'($urandom_range(0, 1));
        opcode = 6'($urandom);
        addr = $urandom;
        wdata = $urandom;
        lat = 1;
        while (!done && lat < 12) begin
            @(posedge clk); #2;
            lat++;
        end
        if (!done) begin
            ntotal++;
            $display("FAIL done_timeout: op %h got no done by cycle %0d, required done", op, lat);
        end
        flt = fault;
        ld = load_data;
        req_valid = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat;
        logic flt;
        logic [31:0] ld;
        int sc;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Give every memory byte a known value.
        for (int i = 0; i < 64; i++) run_req(SW, 32'(i * 4), $urandom, lat, flt, ld);

        run_req(SW, 32'h10, 32'hDEADBEEF, lat, flt, ld);
        chk("sw_latency", 32'(lat), 32'd5);
        chk("sw_fault", 32'(flt), 32'd0);
        chk("sw_byte10", 32'(tb_mem[8'h10]), 32'hDE);
        chk("sw_byte11", 32'(tb_mem[8'h11]), 32'hAD);
        chk("sw_byte12", 32'(tb_mem[8'h12]), 32'hBE);
        chk("sw_byte13", 32'(tb_mem[8'h13]), 32'hEF);

        run_req(SW, 32'h20, 32'h80017FFF, lat, flt, ld);
        run_req(LW, 32'h20, 32'd0, lat, flt, ld);
        chk("lw_latency", 32'(lat), 32'd6);
        chk("lw_data", ld, 32'h80017FFF);
        run_req(LH, 32'h20, 32'd0, lat, flt, ld);
        chk("lh_latency", 32'(lat), 32'd4);
        chk("lh_data", ld, 32'hFFFF8001);
        run_req(LHU, 32'h20, 32'd0, lat, flt, ld);
        chk("lhu_data", ld, 32'h00008001);
        run_req(LB, 32'h22, 32'd0, lat, flt, ld);
        chk("lb_latency", 32'(lat), 32'd3);
        chk("lb_data", ld, 32'h0000007F);
        run_req(LBU, 32'h20, 32'd0, lat, flt, ld);
        chk("lbu_data", ld, 32'h00000080);

        sc = strobe_cnt;
        run_req(LW, 32'h21, 32'd0, lat, flt, ld);
        chk("lw_mis_latency", 32'(lat), 32'd1);
        chk("lw_mis_fault", 32'(flt), 32'd1);
        chk("lw_mis_load_held", ld, 32'h00000080);
        chk("lw_mis_no_strobe", 32'(strobe_cnt - sc), 32'd0);
        sc = strobe_cnt;
        run_req(SH, 32'h11, 32'h1234, lat, flt, ld);
        chk("sh_mis_latency", 32'(lat), 32'd1);
        chk("sh_mis_fault", 32'(flt), 32'd1);
        chk("sh_mis_no_strobe", 32'(strobe_cnt - sc), 32'd0);
        chk("sh_mis_mem_held", 32'(tb_mem[8'h11]), 32'hAD);
        sc = strobe_cnt;
        run_req(SB, 32'h100, 32'h55, lat, flt, ld);
        chk("sb_range_fault", 32'(flt), 32'd1);
        chk("sb_range_no_strobe", 32'(strobe_cnt - sc), 32'd0);

        // Back-to-back with req_valid held through the first request.
        req_valid = 1'b1;
        opcode = SB;
        addr = 32'h05;
        wdata = 32'h123456AA;
        @(posedge clk); #2;
        opcode = LBU;
        addr = 32'h05;
        wdata = 32'd0;
        lat = 1;
        while (!done && lat < 12) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("b2b_sb_latency", 32'(lat), 32'd2);
        @(posedge clk); #2;
        chk("b2b_ready_after_done", 32'(req_ready), 32'd1);
        @(posedge clk); #2;
        chk("b2b_lbu_accepted", 32'(busy), 32'd1);
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 12) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("b2b_lbu_latency", 32'(lat), 32'd3);
        chk("b2b_lbu_data", load_data, 32'h000000AA);
        @(posedge clk); #2;

        // Reset in the second byte cycle of a word store.
        run_req(SW, 32'h30, 32'hA5A5A5A5, lat, flt, ld);
        req_valid = 1'b1;
        opcode = SW;
        addr = 32'h30;
        wdata = 32'h11223344;
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        chk("midrst_load_data", load_data, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("midrst_byte30", 32'(tb_mem[8'h30]), 32'h11);
        chk("midrst_byte32", 32'(tb_mem[8'h32]), 32'hA5);
        chk("midrst_byte33", 32'(tb_mem[8'h33]), 32'hA5);
        run_req(LBU, 32'h30, 32'd0, lat, flt, ld);
        chk("midrst_next_latency", 32'(lat), 32'd3);
        chk("midrst_next_data", ld, 32'h00000011);

        // Illegal opcode is ignored.
        req_valid = 1'b1;
        opcode = 6'h00;
        addr = 32'h40;
        repeat (3) begin
            @(posedge clk); #2;
            chk("illegal_busy", 32'(busy), 32'd0);
            chk("illegal_done", 32'(done), 32'd0);
            chk("illegal_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        end
        req_valid = 1'b0;
        @(posedge clk); #2;

        // Random requests: latency and fault from plain rules; the rest
        // is covered by the per-cycle compare.
        for (int k = 0; k < 300; k++) begin
            logic [5:0] op;
            logic [31:0] a;
            int n;
            int explat;
            if ($urandom_range(0, 9) == 0) begin
                do op = 6'($urandom); while (legal(op));
                req_valid = 1'b1;
                opcode = op;
                addr = $urandom;
                @(posedge clk); #2;
                req_valid = 1'b0;
                chk("rnd_illegal_busy", 32'(busy), 32'd0);
                continue;
            end
            op = OPS[$urandom_range(0, 7)];
            n = op_bytes(op);
            a = 32'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0: a = a | (32'd1 << $urandom_range(8, 31));
                1: ;
                default: a = a & ~32'(n - 1);
            endcase
            run_req(op, a, $urandom, lat, flt, ld);
            explat = is_bad(op, a) ? 1 : (is_ld(op) ? n + 2 : n + 1);
            chk("rnd_latency", 32'(lat), 32'(explat));
            chk("rnd_fault", 32'(flt), 32'(is_bad(op, a)));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
